// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC launch/capture path and the delay line.
// FSM state codes, result field positions and the popcount width helper.
package tdc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LAUNCH  = 3'd1,
      ST_SAMPLE  = 3'd2,
      ST_ENCODE  = 3'd3,
      ST_RECOVER = 3'd4,
      ST_OUT     = 3'd5
   } tdc_state_e;

   localparam int RES_W       = 8;
   localparam int RES_SAT     = 7;
   localparam int RES_ZERO    = 6;
   localparam int RES_MEAN_HI = 5;
   localparam int RES_MEAN_LO = 0;
   localparam int MEAN_W      = RES_MEAN_HI - RES_MEAN_LO + 1;

   function automatic int pop_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/tdc_launch_capture_if.sv
// Result handshake between the launch/capture block and its consumer.
// Master presents res_o/res_valid; slave returns res_ready.
interface tdc_launch_capture_if;
   import tdc_pkg::*;

   logic [RES_W-1:0] res_o;
   logic             res_valid;
   logic             res_ready;

   modport master (
      output res_o,
      output res_valid,
      input  res_ready
   );

   modport slave (
      input  res_o,
      input  res_valid,
      output res_ready
   );

endinterface

// File: rtl/tdc_thermo_popcount.sv
// Bubble-tolerant thermometer encoder: counts set taps.
// Each bubble costs at most one LSB, unlike a first-zero search.
module tdc_thermo_popcount
   import tdc_pkg::*;
#(
   parameter int N_DELAY = 32
) (
   input  logic [N_DELAY-1:0]          bits,
   output logic [pop_w(N_DELAY)-1:0]   ones
);

   localparam int PW = pop_w(N_DELAY);

   always_comb begin
      ones = '0;
      for (int i = 0; i < N_DELAY; i++) begin
         ones = ones + PW'(bits[i]);
      end
   end

endmodule

// File: rtl/tdc_launch_capture.sv
// Launches the delay-line start edge, captures the thermometer code,
// encodes it and averages 2^AVG_LOG2 shots into an 8-bit result.
module tdc_launch_capture
   import tdc_pkg::*;
#(
   parameter int N_DELAY  = 32,
   parameter int SETTLE   = 2,
   parameter int AVG_LOG2 = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 trig,
   output logic                 start_o,
   input  logic [N_DELAY-1:0]   therm_i,
   output logic                 busy,
   tdc_launch_capture_if.master res
);

   localparam int PW = pop_w(N_DELAY);
   localparam int AW = PW + AVG_LOG2;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int SW = AVG_LOG2 + 1;

   localparam logic [SW-1:0] SHOTS    = SW'(1 << AVG_LOG2);
   localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
   localparam logic [PW-1:0] FULL     = PW'(N_DELAY);

   tdc_state_e state;
   tdc_state_e state_n;

   logic [CW-1:0]      cnt;
   logic [SW-1:0]      shots;
   logic [AW-1:0]      acc;
   logic [AW-1:0]      acc_avg;
   logic               sat;
   logic               zero;
   logic [N_DELAY-1:0] cap1;
   logic [N_DELAY-1:0] cap2;
   logic [PW-1:0]      ones;
   logic [RES_W-1:0]   res_d;
   logic               settle_done;
   logic               shots_done;
   logic               take;

   tdc_thermo_popcount #(
      .N_DELAY (N_DELAY)
   ) u_pop (
      .bits (cap2),
      .ones (ones)
   );

   assign settle_done = (cnt == CNT_LAST);
   assign shots_done  = (shots == SHOTS);
   assign take        = res.res_valid && res.res_ready;
   assign start_o     = (state == ST_LAUNCH) || (state == ST_SAMPLE);
   assign busy        = (state != ST_IDLE);
   assign acc_avg     = acc >> AVG_LOG2;

   always_comb begin
      res_d = '0;
      res_d[RES_SAT]  = sat;
      res_d[RES_ZERO] = zero;
      res_d[RES_MEAN_HI:RES_MEAN_LO] = MEAN_W'(acc_avg);
   end

   always_comb begin
      state_n = state;
      unique case (state)
         ST_IDLE: begin
            if (trig) state_n = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            if (settle_done) state_n = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            state_n = ST_ENCODE;
         end
         ST_ENCODE: begin
            state_n = ST_RECOVER;
         end
         ST_RECOVER: begin
            if (settle_done) begin
               state_n = shots_done ? ST_OUT : ST_LAUNCH;
            end
         end
         ST_OUT: begin
            if (take) state_n = ST_IDLE;
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state_n != state) begin
         cnt <= '0;
      end else if (state == ST_LAUNCH || state == ST_RECOVER) begin
         cnt <= cnt + CW'(1);
      end
   end

   // therm_i is asynchronous: two flops, only the second one is encoded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap1 <= '0;
         cap2 <= '0;
      end else begin
         cap1 <= therm_i;
         cap2 <= cap1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         shots <= '0;
         sat   <= 1'b0;
         zero  <= 1'b0;
      end else if (state == ST_IDLE && trig) begin
         acc   <= '0;
         shots <= '0;
         sat   <= 1'b0;
         zero  <= 1'b0;
      end else if (state == ST_ENCODE) begin
         acc   <= acc + AW'(ones);
         shots <= shots + SW'(1);
         sat   <= sat | (ones == FULL);
         zero  <= zero | (ones == '0);
      end
   end

   // res_o latches on OUT entry; valid follows one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res.res_o     <= '0;
         res.res_valid <= 1'b0;
      end else begin
         if (state == ST_RECOVER && state_n == ST_OUT) begin
            res.res_o <= res_d;
         end
         if (take) begin
            res.res_valid <= 1'b0;
         end else if (state == ST_OUT) begin
            res.res_valid <= 1'b1;
         end
      end
   end

endmodule
